pipe_hazard_ctrl: RTL and testbench

- Central hazard and sequencing controller for the 5-stage MIPS pipeline.
- Watches the ID, EX and MEM stages and produces the PC select/enable, per-register write enables and flushes for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles load-use stalls, taken-branch and overflow redirects, and data-memory wait freezes, with a timeout monitor.

---
 rtl/pipe_hazard_ctrl_if.sv | 63 ++++++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Purpose  : Pipeline-stage status inputs and hazard-control outputs for
//             pipe_hazard_ctrl. With HAZ_PERF_CNT_EN defined, the stall and
//             flush performance counters are carried as well.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic [REG_ADDR_W-1:0] i_ID_RsAddr;
    logic [REG_ADDR_W-1:0] i_ID_RtAddr;
    logic                  i_ID_UsesRt;
    logic                  i_EX_MemRead;
    logic [REG_ADDR_W-1:0] i_EX_RegAddrW;
    logic                  i_MEM_Branch;
    logic                  i_MEM_Zero;
    logic                  i_MEM_Overflow;
    logic                  i_MEM_Busy;
    logic                  o_PCWrite;
    logic [1:0]            o_PCSel;
    logic                  o_IFID_Write;
    logic                  o_IFID_Flush;
    logic                  o_IDEX_Write;
    logic                  o_IDEX_Flush;
    logic                  o_EXMEM_Write;
    logic                  o_EXMEM_Flush;
    logic                  o_MemTimeout;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]           o_StallCnt;
    logic [31:0]           o_FlushCnt;

    modport master (
        output i_ID_RsAddr, i_ID_RtAddr, i_ID_UsesRt, i_EX_MemRead, i_EX_RegAddrW,
               i_MEM_Branch, i_MEM_Zero, i_MEM_Overflow, i_MEM_Busy,
        input  o_PCWrite, o_PCSel, o_IFID_Write, o_IFID_Flush, o_IDEX_Write,
               o_IDEX_Flush, o_EXMEM_Write, o_EXMEM_Flush, o_MemTimeout,
               o_StallCnt, o_FlushCnt
    );
    modport slave (
        input  i_ID_RsAddr, i_ID_RtAddr, i_ID_UsesRt, i_EX_MemRead, i_EX_RegAddrW,
               i_MEM_Branch, i_MEM_Zero, i_MEM_Overflow, i_MEM_Busy,
        output o_PCWrite, o_PCSel, o_IFID_Write, o_IFID_Flush, o_IDEX_Write,
               o_IDEX_Flush, o_EXMEM_Write, o_EXMEM_Flush, o_MemTimeout,
               o_StallCnt, o_FlushCnt
    );
`else
    modport master (
        output i_ID_RsAddr, i_ID_RtAddr, i_ID_UsesRt, i_EX_MemRead, i_EX_RegAddrW,
               i_MEM_Branch, i_MEM_Zero, i_MEM_Overflow, i_MEM_Busy,
        input  o_PCWrite, o_PCSel, o_IFID_Write, o_IFID_Flush, o_IDEX_Write,
               o_IDEX_Flush, o_EXMEM_Write, o_EXMEM_Flush, o_MemTimeout
    );
    modport slave (
        input  i_ID_RsAddr, i_ID_RtAddr, i_ID_UsesRt, i_EX_MemRead, i_EX_RegAddrW,
               i_MEM_Branch, i_MEM_Zero, i_MEM_Overflow, i_MEM_Busy,
        output o_PCWrite, o_PCSel, o_IFID_Write, o_IFID_Flush, o_IDEX_Write,
               o_IDEX_Flush, o_EXMEM_Write, o_EXMEM_Flush, o_MemTimeout
    );
`endif
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard/sequencing controller for a 5-stage MIPS pipeline.
//             Resolves memory-wait freezes, overflow and taken-branch
//             redirects and load-use stalls, with a sticky memory timeout.
//             Optional macro HAZ_PERF_CNT_EN adds stall/flush counters.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 64
) (
    input wire                clk,
    input wire                nrst,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    localparam logic [7:0] c_TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);
    localparam logic [7:0] c_CNT_MAX    = 8'hFF;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic [REG_ADDR_W-1:0] w_id_rs, w_id_rt, w_ex_rd;
    logic                  w_load_use;
    logic                  w_redirect_ok;
    logic                  w_stall_evt;
    logic                  w_flush_evt;

    logic       pc_write;
    logic [1:0] pc_sel;
    logic       ifid_write, ifid_flush;
    logic       idex_write, idex_flush;
    logic       exmem_write, exmem_flush;

    assign w_id_rs = hz.i_ID_RsAddr;
    assign w_id_rt = hz.i_ID_RtAddr;
    assign w_ex_rd = hz.i_EX_RegAddrW;

    // A load in EX whose non-$0 destination feeds the ID instruction
    assign w_load_use = hz.i_EX_MemRead && (w_ex_rd != '0) &&
                        ((w_ex_rd == w_id_rs) || (hz.i_ID_UsesRt && (w_ex_rd == w_id_rt)));

    // MEM holds a bubble right after a redirect, so its flags are stale
    assign w_redirect_ok = (state_q != ST_FLUSH);

    // Next-state and control decode: reset > busy > overflow > branch > load-use
    always_comb begin
        pc_write    = 1'b1;
        pc_sel      = 2'b00;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_flush  = 1'b0;
        exmem_write = 1'b1;
        exmem_flush = 1'b0;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        w_stall_evt = 1'b0;
        w_flush_evt = 1'b0;

        if (!nrst) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_write  = 1'b0;
            idex_flush  = 1'b1;
            exmem_write = 1'b0;
            exmem_flush = 1'b1;
        end else if (hz.i_MEM_Busy) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            state_d     = ST_MEMWAIT;
            wait_cnt_d  = (wait_cnt_q == c_CNT_MAX) ? c_CNT_MAX : wait_cnt_q + 8'd1;
            if (wait_cnt_q == c_TIMEOUT_M1) begin
                timeout_d = 1'b1;
            end
            w_stall_evt = 1'b1;
        end else begin
            wait_cnt_d = 8'd0;
            state_d    = ST_RUN;
            if (w_redirect_ok && (hz.i_MEM_Overflow || (hz.i_MEM_Branch && hz.i_MEM_Zero))) begin
                pc_sel      = hz.i_MEM_Overflow ? 2'b10 : 2'b01;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
                state_d     = ST_FLUSH;
                w_flush_evt = 1'b1;
            end else if (w_load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_flush  = 1'b1;
                w_stall_evt = 1'b1;
            end
        end
    end

    // State, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hz.o_PCWrite     = pc_write;
    assign hz.o_PCSel       = pc_sel;
    assign hz.o_IFID_Write  = ifid_write;
    assign hz.o_IFID_Flush  = ifid_flush;
    assign hz.o_IDEX_Write  = idex_write;
    assign hz.o_IDEX_Flush  = idex_flush;
    assign hz.o_EXMEM_Write = exmem_write;
    assign hz.o_EXMEM_Flush = exmem_flush;
    assign hz.o_MemTimeout  = timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Free-running wrap-around event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, w_stall_evt};
        flush_cnt_d = flush_cnt_q + {31'd0, w_flush_evt};
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (!nrst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.o_StallCnt = stall_cnt_q;
    assign hz.o_FlushCnt = flush_cnt_q;
`else
    logic w_unused_evt;
    assign w_unused_evt = w_stall_evt ^ w_flush_evt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             followed by randomized traffic against a rule-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int MEM_TIMEOUT = 64;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_ADDR_W(5)) hz();

    pipe_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .hz   (hz)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Model: consecutive busy cycles so far, whether the previous cycle
    // redirected (MEM now holds a bubble), and the sticky timeout.
    int          busy_run   = 0;
    bit          last_redir = 1'b0;
    bit          sticky     = 1'b0;
    bit [31:0]   exp_stall  = 32'd0;
    bit [31:0]   exp_flush  = 32'd0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare all outputs, then advance model.
    task automatic step(input bit rst_n, input bit [4:0] rs, input bit [4:0] rt,
                        input bit uses_rt, input bit ex_mr, input bit [4:0] ex_rd,
                        input bit br, input bit zero, input bit ovf, input bit busy);
        bit [8:0] exp_ctl;
        bit       lu;
        bit       redir;
        @(negedge clk);
        nrst                = rst_n;
        hz.i_ID_RsAddr      = rs;
        hz.i_ID_RtAddr      = rt;
        hz.i_ID_UsesRt      = uses_rt;
        hz.i_EX_MemRead     = ex_mr;
        hz.i_EX_RegAddrW    = ex_rd;
        hz.i_MEM_Branch     = br;
        hz.i_MEM_Zero       = zero;
        hz.i_MEM_Overflow   = ovf;
        hz.i_MEM_Busy       = busy;
        #2;
        lu    = ex_mr && (ex_rd != 5'd0) && ((ex_rd == rs) || (uses_rt && (ex_rd == rt)));
        redir = 1'b0;
        // {PCWrite, PCSel, IFID_W, IFID_F, IDEX_W, IDEX_F, EXMEM_W, EXMEM_F}
        if (!rst_n)                        exp_ctl = 9'b0_00_01_01_01;
        else if (busy)                     exp_ctl = 9'b0_00_00_00_00;
        else if (!last_redir && ovf)       begin exp_ctl = 9'b1_10_11_11_11; redir = 1'b1; end
        else if (!last_redir && br && zero) begin exp_ctl = 9'b1_01_11_11_11; redir = 1'b1; end
        else if (lu)                       exp_ctl = 9'b0_00_00_11_10;
        else                               exp_ctl = 9'b1_00_10_10_10;
        check_val("ctl", {23'd0, hz.o_PCWrite, hz.o_PCSel, hz.o_IFID_Write, hz.o_IFID_Flush,
                          hz.o_IDEX_Write, hz.o_IDEX_Flush, hz.o_EXMEM_Write, hz.o_EXMEM_Flush},
                  {23'd0, exp_ctl});
        check_val("timeout", {31'd0, hz.o_MemTimeout}, {31'd0, sticky});
`ifdef HAZ_PERF_CNT_EN
        check_val("stall_cnt", hz.o_StallCnt, exp_stall);
        check_val("flush_cnt", hz.o_FlushCnt, exp_flush);
`endif
        if (!rst_n) begin
            busy_run = 0; last_redir = 1'b0; sticky = 1'b0;
            exp_stall = 32'd0; exp_flush = 32'd0;
        end else if (busy) begin
            busy_run++;
            if (busy_run == MEM_TIMEOUT) sticky = 1'b1;
            last_redir = 1'b0;
            exp_stall++;
        end else begin
            busy_run   = 0;
            last_redir = redir;
            if (redir) exp_flush++;
            else if (lu) exp_stall++;
        end
    endtask

    task automatic idle(input bit rst_n);
        step(rst_n, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int burst;
        // Reset behaviour
        idle(1'b0);
        idle(1'b0);
        check_val("rst_pcwrite", {31'd0, hz.o_PCWrite}, 32'd0);
        check_val("rst_idex_flush", {31'd0, hz.o_IDEX_Flush}, 32'd1);
        idle(1'b1);
        check_val("dflt_pcwrite", {31'd0, hz.o_PCWrite}, 32'd1);

        // Load-use on $8: one bubble, then defaults
        step(1'b1, 5'd8, 5'd3, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("lu_ifid_write", {31'd0, hz.o_IFID_Write}, 32'd0);
        check_val("lu_idex_flush", {31'd0, hz.o_IDEX_Flush}, 32'd1);
        idle(1'b1);
        // Load-use through rt
        step(1'b1, 5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        // $0 never stalls
        step(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("zero_reg_pcwrite", {31'd0, hz.o_PCWrite}, 32'd1);

        // Taken branch, then FLUSH cycle ignores a second taken branch
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("br_pcsel", {30'd0, hz.o_PCSel}, 32'd1);
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("flush_pcsel", {30'd0, hz.o_PCSel}, 32'd0);

        // Overflow beats branch; next cycle is FLUSH and ignores overflow
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0);
        check_val("ovf_pcsel", {30'd0, hz.o_PCSel}, 32'd2);
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("ovf_flush_pcsel", {30'd0, hz.o_PCSel}, 32'd0);

        // Busy 3 cycles with a taken branch held in MEM, redirect on the 4th
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1);
            check_val("busy_exmem_write", {31'd0, hz.o_EXMEM_Write}, 32'd0);
        end
        step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_val("busy_br_pcsel", {30'd0, hz.o_PCSel}, 32'd1);
        check_val("busy_short_tmo", {31'd0, hz.o_MemTimeout}, 32'd0);
        idle(1'b1);

        // Long busy: timeout appears once MEM_TIMEOUT busy edges have passed
        for (int i = 0; i < MEM_TIMEOUT; i++)
            step(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check_val("tmo_set", {31'd0, hz.o_MemTimeout}, 32'd1);
        idle(1'b1);
        idle(1'b1);
        check_val("tmo_sticky", {31'd0, hz.o_MemTimeout}, 32'd1);
        idle(1'b0);
        idle(1'b1);
        check_val("tmo_cleared", {31'd0, hz.o_MemTimeout}, 32'd0);

        // Randomized traffic with occasional resets and busy bursts
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            bit b;
            if (burst > 0) begin
                b = 1'b1;
                burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                b = 1'b1;
                burst = ($urandom_range(0, 9) == 0) ? $urandom_range(50, 90) : $urandom_range(0, 4);
            end else begin
                b = 1'b0;
            end
            step(($urandom_range(0, 149) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0), 1'($urandom),
                 ($urandom_range(0, 7) == 0), b);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
